// File: rtl/test_end_monitor.sv
// Test-completion monitor: watches the decode PC stream for programmable end
// addresses, samples a result register after a settle delay and reports
// pass/fail. It also flags a global timeout and a PC hang.
module test_end_monitor #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_END      = 2,
  parameter int IDX_W      = 1,
  parameter int CNT_W      = 24,
  parameter int SAMPLE_DLY = 1,
  parameter int HANG_LIMIT = 64
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst,
  input  logic                      start,
  input  logic                      pc_valid,
  input  logic [PC_WIDTH-1:0]       pc,
  input  logic [N_END*PC_WIDTH-1:0] end_addr,
  input  logic [N_END-1:0]          end_en,
  input  logic [DATA_WIDTH-1:0]     result_val,
  input  logic [DATA_WIDTH-1:0]     pass_val,
  input  logic [CNT_W-1:0]          timeout_limit,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic                      hang,
  output logic [IDX_W-1:0]          end_idx,
  output logic [PC_WIDTH-1:0]       pc_at_end,
  output logic [CNT_W-1:0]          cycle_cnt
);

  // The hang counter only has to reach HANG_LIMIT; keep at least one bit.
  localparam int HANG_W = (HANG_LIMIT > 0) ? $clog2(HANG_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  state_t                state_q, state_d;
  logic [HANG_W-1:0]     hang_cnt, hang_cnt_d;
  logic [PC_WIDTH-1:0]   last_pc, last_pc_d;
  logic                  have_last, have_last_d;
  logic [3:0]            settle_cnt, settle_cnt_d;
  logic                  done_d, pass_d, fail_d, timeout_d, hang_d;
  logic [IDX_W-1:0]      end_idx_d;
  logic [PC_WIDTH-1:0]   pc_at_end_d;
  logic [CNT_W-1:0]      cycle_cnt_d, cnt_sat_inc;
  logic                  match;
  logic [IDX_W-1:0]      match_idx;
  logic                  repeat_pc, hang_hit, timeout_hit;
  logic [HANG_W-1:0]     hang_cnt_inc;

  // Find the lowest enabled channel whose end address equals the current PC;
  // scanning downward lets the lowest index overwrite higher ones.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = N_END - 1; i >= 0; i--) begin
      if (pc_valid && end_en[i] && (pc == end_addr[i*PC_WIDTH +: PC_WIDTH])) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // Terminal-condition helpers: saturating cycle count, hang and timeout hits.
  always_comb begin
    cnt_sat_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    hang_cnt_inc = hang_cnt + HANG_W'(1);
    repeat_pc    = pc_valid && have_last && (pc == last_pc);
    hang_hit     = (HANG_LIMIT != 0) && repeat_pc && (hang_cnt_inc == HANG_W'(HANG_LIMIT));
    timeout_hit  = (timeout_limit != '0) && (cycle_cnt == timeout_limit);
  end

  // Next-state and next-output logic; start overrides everything except reset.
  always_comb begin
    state_d      = state_q;
    hang_cnt_d   = hang_cnt;
    last_pc_d    = last_pc;
    have_last_d  = have_last;
    settle_cnt_d = settle_cnt;
    done_d       = done;
    pass_d       = pass;
    fail_d       = fail;
    timeout_d    = timeout;
    hang_d       = hang;
    end_idx_d    = end_idx;
    pc_at_end_d  = pc_at_end;
    cycle_cnt_d  = cycle_cnt;

    if (start) begin
      state_d      = RUN;
      hang_cnt_d   = '0;
      last_pc_d    = '0;
      have_last_d  = 1'b0;
      settle_cnt_d = '0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      timeout_d    = 1'b0;
      hang_d       = 1'b0;
      end_idx_d    = '0;
      pc_at_end_d  = '0;
      cycle_cnt_d  = '0;
    end else begin
      case (state_q)
        RUN: begin
          cycle_cnt_d = cnt_sat_inc;
          if (pc_valid) begin
            if (repeat_pc) begin
              hang_cnt_d = hang_cnt_inc;
            end else begin
              hang_cnt_d  = '0;
              last_pc_d   = pc;
              have_last_d = 1'b1;
            end
          end
          if (match) begin
            end_idx_d    = match_idx;
            pc_at_end_d  = pc;
            settle_cnt_d = 4'(SAMPLE_DLY);
            state_d      = SETTLE;
          end else if (hang_hit) begin
            hang_d      = 1'b1;
            done_d      = 1'b1;
            pc_at_end_d = pc;
            state_d     = DONE;
          end else if (timeout_hit) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
        SETTLE: begin
          cycle_cnt_d = cnt_sat_inc;
          if (settle_cnt == 4'd0) begin
            pass_d  = (result_val == pass_val);
            fail_d  = (result_val != pass_val);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            settle_cnt_d = settle_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= IDLE;
      hang_cnt   <= '0;
      last_pc    <= '0;
      have_last  <= 1'b0;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      hang       <= 1'b0;
      end_idx    <= '0;
      pc_at_end  <= '0;
      cycle_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      hang_cnt   <= hang_cnt_d;
      last_pc    <= last_pc_d;
      have_last  <= have_last_d;
      settle_cnt <= settle_cnt_d;
      done       <= done_d;
      pass       <= pass_d;
      fail       <= fail_d;
      timeout    <= timeout_d;
      hang       <= hang_d;
      end_idx    <= end_idx_d;
      pc_at_end  <= pc_at_end_d;
      cycle_cnt  <= cycle_cnt_d;
    end
  end

endmodule

// File: tb/tb_test_end_monitor.sv
// Self-checking bench for test_end_monitor: expected end-of-test records are
// queued when the ending stimulus is driven and compared when done rises.
module tb_test_end_monitor;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst, start, pc_valid;
  logic [31:0] pc;
  logic [63:0] end_addr;
  logic [1:0]  end_en;
  logic [31:0] result_val, pass_val;
  logic [23:0] timeout_limit;
  logic        done, pass, fail, timeout, hang;
  logic [0:0]  end_idx;
  logic [31:0] pc_at_end;
  logic [23:0] cycle_cnt;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        hang;
    logic [0:0]  idx;
    logic [31:0] pc;
    logic [23:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  test_end_monitor #(.HANG_LIMIT(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .start(start), .pc_valid(pc_valid),
    .pc(pc), .end_addr(end_addr), .end_en(end_en), .result_val(result_val),
    .pass_val(pass_val), .timeout_limit(timeout_limit), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .hang(hang), .end_idx(end_idx),
    .pc_at_end(pc_at_end), .cycle_cnt(cycle_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic exp_t actual();
    return {done, pass, fail, timeout, hang, end_idx, pc_at_end, cycle_cnt};
  endfunction

  // One clock edge; inputs and samples both sit 1 time unit after the edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        expired = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    exp_t act;
    cpu_rst = 1'b1;
    tick();
    tick();
    act = actual();
    checks++;
    if (act !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", act);
    end
    cpu_rst = 1'b0;
    tick();
    checks++;
    if (actual() !== '0) begin
      failures++;
      $display("[TB] FAIL idle_no_start: got %h expected 0", actual());
    end
  endtask

  // Stream 0x0..0x48, then corrupt result_val on the first settle edge so only
  // sampling at exactly two edges after the match gives the queued answer.
  task automatic test_pass_fail();
    logic [31:0] results [2];
    exp_t e, act;
    results[0] = 32'h1;
    results[1] = 32'h5;
    end_addr = {32'hFFFF_FFF0, 32'h48};
    end_en = 2'b01;
    pass_val = 32'h1;
    timeout_limit = '0;
    for (int r = 0; r < 2; r++) begin
      result_val = results[r];
      arm();
      for (int a = 0; a <= 32'h48; a += 4) begin
        pc_valid = 1'b1;
        pc = 32'(a);
        if (a == 32'h48)
          sb_q.push_back('{1'b1, results[r] == 32'h1, results[r] != 32'h1, 1'b0, 1'b0,
                           1'b0, 32'h48, 24'd21});
        tick();
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL early_done pc=%h: got %b expected 0", a, done);
        end
      end
      pc_valid = 1'b0;
      result_val = 32'hBAD;
      tick();
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL settle_done: got %b expected 0", done);
      end
      result_val = results[r];
      tick();
      e = sb_q.pop_front();
      act = actual();
      checks++;
      if (act !== e) begin
        failures++;
        $display("[TB] FAIL result_run%0d: got %h expected %h", r, act, e);
      end
      pc_valid = 1'b1;
      pc = 32'h48;
      result_val = results[r] ^ 32'h3;
      tick();
      tick();
      act = actual();
      checks++;
      if (act !== e) begin
        failures++;
        $display("[TB] FAIL done_frozen_run%0d: got %h expected %h", r, act, e);
      end
      pc_valid = 1'b0;
    end
  endtask

  task automatic test_priority();
    logic [1:0] ens [2];
    bit expired;
    exp_t e, act;
    ens[0] = 2'b11;
    ens[1] = 2'b10;
    end_addr = {32'h100, 32'h100};
    result_val = 32'h1;
    pass_val = 32'h1;
    timeout_limit = '0;
    for (int k = 0; k < 2; k++) begin
      end_en = ens[k];
      arm();
      pc_valid = 1'b1;
      pc = 32'h100;
      sb_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'(k), 32'h100, 24'd3});
      tick();
      pc_valid = 1'b0;
      wait_done(10, expired);
      e = sb_q.pop_front();
      act = actual();
      checks++;
      if (expired || act !== e) begin
        failures++;
        $display("[TB] FAIL priority_en%b: got %h expected %h (expired=%0b)", ens[k], act, e, expired);
      end
    end
  endtask

  // End addresses are disabled, so only the timeout can end the first run.
  task automatic test_timeout();
    exp_t e, act;
    bit saw_done;
    end_addr = {32'h104, 32'h100};
    end_en = 2'b00;
    timeout_limit = 24'd10;
    arm();
    sb_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 24'd11});
    for (int i = 0; i < 11; i++) begin
      pc_valid = 1'b1;
      pc = 32'h100 + 32'(i * 4);
      tick();
      if (i == 9) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL timeout_early: got %b expected 0", done);
        end
      end
    end
    e = sb_q.pop_front();
    act = actual();
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL timeout_11th_edge: got %h expected %h", act, e);
    end
    timeout_limit = '0;
    arm();
    saw_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      pc = 32'h200 + 32'(i * 4);
      tick();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || cycle_cnt !== 24'd1000) begin
      failures++;
      $display("[TB] FAIL timeout_disabled: got done_seen=%0b cnt=%0d expected 0 and 1000", saw_done, cycle_cnt);
    end
    pc_valid = 1'b0;
  endtask

  // Valid 0x80 edges interleaved with invalid edges carrying another PC.
  task automatic test_hang();
    exp_t e, act;
    end_addr = {32'hFFFF_FFF0, 32'h80};
    result_val = 32'h1;
    pass_val = 32'h1;
    timeout_limit = '0;
    for (int k = 0; k < 2; k++) begin
      end_en = 2'b00;
      arm();
      if (k == 0)
        sb_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 24'd9});
      else
        sb_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 24'd11});
      for (int v = 0; v < 5; v++) begin
        if (v == 4 && k == 1) end_en = 2'b01;
        pc_valid = 1'b1;
        pc = 32'h80;
        tick();
        if (v < 4) begin
          pc_valid = 1'b0;
          pc = 32'h999;
          tick();
        end
      end
      pc_valid = 1'b0;
      if (k == 0) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL hang_5th_valid: got done=%b expected 1", done);
        end
      end else begin
        tick();
        tick();
      end
      e = sb_q.pop_front();
      act = actual();
      checks++;
      if (act !== e) begin
        failures++;
        $display("[TB] FAIL hang_case%0d: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_abort_reset();
    bit expired;
    exp_t e, act;
    end_addr = {32'hFFFF_FFF0, 32'h48};
    end_en = 2'b01;
    result_val = 32'h1;
    pass_val = 32'h1;
    timeout_limit = '0;
    arm();
    pc_valid = 1'b1;
    pc = 32'h48;
    tick();
    pc_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || cycle_cnt !== 24'd0) begin
      failures++;
      $display("[TB] FAIL abort_settle: got done=%b cnt=%0d expected 0 and 0", done, cycle_cnt);
    end
    tick();
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || cycle_cnt !== 24'd3) begin
      failures++;
      $display("[TB] FAIL abort_no_sample: got done=%b pass=%b cnt=%0d expected 0 0 3", done, pass, cycle_cnt);
    end
    cpu_rst = 1'b1;
    start = 1'b1;
    tick();
    cpu_rst = 1'b0;
    start = 1'b0;
    checks++;
    if (actual() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got %h expected 0", actual());
    end
    tick();
    tick();
    checks++;
    if (actual() !== '0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got %h expected 0", actual());
    end
    arm();
    pc_valid = 1'b1;
    pc = 32'h48;
    sb_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48, 24'd3});
    tick();
    pc_valid = 1'b0;
    wait_done(10, expired);
    e = sb_q.pop_front();
    act = actual();
    checks++;
    if (expired || act !== e) begin
      failures++;
      $display("[TB] FAIL resume_after_reset: got %h expected %h (expired=%0b)", act, e, expired);
    end
  endtask

  initial begin
    cpu_rst = 1'b1;
    start = 1'b0;
    pc_valid = 1'b0;
    pc = '0;
    end_addr = '0;
    end_en = '0;
    result_val = '0;
    pass_val = '0;
    timeout_limit = '0;
    test_reset();
    test_pass_fail();
    test_priority();
    test_timeout();
    test_hang();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_end_monitor.md
Name: test_end_monitor

Overview:
- Synthesizable, parametrised test-completion monitor for krv_c simulation and FPGA self-test.
- Watches the decode-stage PC stream for any of N_END programmable end addresses. After a configurable settle delay it samples a result register (gp/x3 in the standard flow) and reports pass or fail.
- Also flags global timeout and PC-hang (same PC retired repeatedly). Status is held until re-armed.

Parameters:
- PC_WIDTH, 32, width of PC and end addresses.
- DATA_WIDTH, 32, width of result/pass values.
- N_END, 2, number of end-address channels (>=1).
- IDX_W, 1, width of end_idx; equals max(1, clog2(N_END)).
- CNT_W, 24, width of the cycle counter and timeout_limit.
- SAMPLE_DLY, 1, settle cycles between end match and result sampling (0..15).
- HANG_LIMIT, 64, consecutive valid repeats of one PC that flag a hang; 0 disables hang detection.

Ports:
- cpu_clk  in  1  core clock.
- cpu_rst  in  1  synchronous active-high reset.
- start  in  1  arm/re-arm pulse; clears all status.
- pc_valid  in  1  pc carries a valid decode PC this cycle.
- pc  in  PC_WIDTH  decode-stage PC.
- end_addr  in  N_END*PC_WIDTH  end addresses; channel i at bits [i*PC_WIDTH +: PC_WIDTH].
- end_en  in  N_END  per-channel enable.
- result_val  in  DATA_WIDTH  value checked at test end.
- pass_val  in  DATA_WIDTH  expected value for pass.
- timeout_limit  in  CNT_W  timeout in cycles; 0 disables timeout.
- done  out  1  test finished (any cause).
- pass  out  1  result matched.
- fail  out  1  result mismatched.
- timeout  out  1  timeout expired.
- hang  out  1  PC hang detected.
- end_idx  out  IDX_W  channel that matched.
- pc_at_end  out  PC_WIDTH  PC that ended the run (match or hang PC).
- cycle_cnt  out  CNT_W  cycles spent in RUN+SETTLE.

Behaviour:
- Clock is cpu_clk, single domain. Reset is synchronous and active-high on cpu_rst.
- Reset: state=IDLE; all outputs 0; internal hang counter and last-PC register 0.
- States: IDLE, RUN, SETTLE, DONE.
- IDLE: start -> RUN. On that transition cycle_cnt, hang counter and all flags are cleared.
- RUN:
  - cycle_cnt increments each edge and saturates at all-ones.
  - Match = pc_valid & end_en[i] & (pc == end_addr[i]). The lowest matching i wins.
  - On match: latch end_idx=i and pc_at_end=pc, load settle counter with SAMPLE_DLY, go to SETTLE.
- Result sampling: with the match sampled at edge E0, result_val is sampled at edge E0+1+SAMPLE_DLY.
  - pass=(result_val==pass_val), fail=~pass.
  - done=1, state=DONE. Flags are visible right after that edge.
- Timeout: in RUN with timeout_limit!=0, at an edge where cycle_cnt (pre-edge) == timeout_limit and no match: timeout=1, done=1, go to DONE. This is the (timeout_limit+1)-th RUN edge.
- Hang:
  - In RUN, on each pc_valid edge: if pc == last_pc, the hang counter increments; otherwise the counter clears and last_pc=pc.
  - Edges without pc_valid leave both unchanged. The first valid PC after arming always loads last_pc and counts as a non-repeat.
  - When the counter reaches HANG_LIMIT: hang=1, done=1, pc_at_end=pc, go to DONE.
- Priority on the same edge: end match > hang > timeout. Only one cause flag is ever set.
- SETTLE: cycle_cnt keeps counting. Timeout and hang are not evaluated. PC input is ignored.
- DONE: all outputs frozen, cycle_cnt frozen. Leaves only on start (-> RUN with clear) or cpu_rst.
- start in RUN or SETTLE aborts the current run and restarts RUN with clear. start has priority over any same-edge match, timeout or hang.
- cpu_rst mid-operation returns to IDLE with all outputs 0, regardless of start.
- end_en all zero: no match possible; only timeout or hang can end the run.

Test Plan:
- Pass: end_addr[0]=0x48, pass_val=1, SAMPLE_DLY=1. Start, stream PCs 0x0,0x4..0x48, result_val=1 -> done=pass=1, end_idx=0, pc_at_end=0x48, result sampled 2 edges after the 0x48 edge.
- Fail: same stimulus with result_val=0x5 -> done=fail=1, pass=0.
- Multi-channel priority: end_addr[0]=end_addr[1]=0x100, both enabled -> end_idx=0. Repeat with end_en=2'b10 -> end_idx=1.
- Timeout: timeout_limit=10, PCs never match and keep changing -> timeout=done=1 on the 11th RUN edge, cycle_cnt=11, pass=fail=0. Repeat with timeout_limit=0 for 1000 cycles -> done stays 0.
- Hang: HANG_LIMIT=4, PC held at 0x80 with pc_valid=1 (invalid cycles interleaved) -> hang=1 after the 5th valid 0x80, pc_at_end=0x80. PC 0x80 also enabled as an end address -> pass/fail path taken instead, hang=0.
- Abort/reset: start during SETTLE -> returns to RUN with cycle_cnt=0 and no result sampled. cpu_rst during RUN -> IDLE, all outputs 0; a later start resumes normally.
